// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the single-port ternary memory: serialises CPU (A) and
// loader/debug (B) transfers with round-robin fairness and a bounded B burst lock.
module mem_arbiter #(
   parameter int WORD_SIZE     = 9,
   parameter int MEM_ADDR_SIZE = 9,
   parameter int READ_LATENCY  = 0,
   parameter int MAX_LOCK      = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       a_req,
   input  logic                       a_we,
   input  logic [2*MEM_ADDR_SIZE-1:0] a_addr,
   input  logic [2*WORD_SIZE-1:0]     a_wdata,
   input  logic                       b_req,
   input  logic                       b_we,
   input  logic [2*MEM_ADDR_SIZE-1:0] b_addr,
   input  logic [2*WORD_SIZE-1:0]     b_wdata,
   input  logic                       b_lock,
   output logic                       a_gnt,
   output logic                       b_gnt,
   output logic                       a_rvalid,
   output logic                       b_rvalid,
   output logic [2*WORD_SIZE-1:0]     rdata,
   output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
   output logic [2*WORD_SIZE-1:0]     mem_write_data,
   output logic                       mem_read,
   output logic                       mem_write,
   input  logic [2*WORD_SIZE-1:0]     mem_read_data,
   output logic                       busy
);

   localparam int DW = 2 * WORD_SIZE;
   localparam int AW = 2 * MEM_ADDR_SIZE;
   localparam logic [1:0]    TRIT_ZERO  = 2'b00;
   localparam logic [DW-1:0] ZERO_WORD  = {WORD_SIZE{TRIT_ZERO}};
   localparam logic [AW-1:0] ZERO_ADDR  = {MEM_ADDR_SIZE{TRIT_ZERO}};
   localparam logic [1:0]    WAIT_INIT  = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;
   localparam logic [3:0]    LOCK_LIMIT = 4'(MAX_LOCK);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic            owner_b_q, owner_b_d;
   logic [3:0]      lock_cnt_q, lock_cnt_d;
   logic            req_we_q, req_we_d;
   logic [1:0]      wait_cnt_q, wait_cnt_d;
   logic            a_gnt_q, a_gnt_d;
   logic            b_gnt_q, b_gnt_d;
   logic            a_rvalid_q, a_rvalid_d;
   logic            b_rvalid_q, b_rvalid_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic            busy_q, busy_d;
   logic [AW-1:0]   mem_address_q, mem_address_d;
   logic [DW-1:0]   mem_write_data_q, mem_write_data_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            lock_win;
   logic            pick_b;

   always_comb begin
      state_d          = state_q;
      owner_b_d        = owner_b_q;
      lock_cnt_d       = lock_cnt_q;
      req_we_d         = req_we_q;
      wait_cnt_d       = wait_cnt_q;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      rdata_d          = rdata_q;
      a_gnt_d          = 1'b0;
      b_gnt_d          = 1'b0;
      a_rvalid_d       = 1'b0;
      b_rvalid_d       = 1'b0;
      mem_read_d       = 1'b0;
      mem_write_d      = 1'b0;

      // owner_b_q doubles as the last-served pointer; the lock only extends a B run
      lock_win = owner_b_q && b_lock && (lock_cnt_q < LOCK_LIMIT);
      pick_b   = b_req && (!a_req || lock_win || !owner_b_q);

      case (state_q)
         IDLE: begin
            if (a_req || b_req) begin
               owner_b_d        = pick_b;
               req_we_d         = pick_b ? b_we    : a_we;
               mem_address_d    = pick_b ? b_addr  : a_addr;
               mem_write_data_d = pick_b ? b_wdata : a_wdata;
               a_gnt_d          = !pick_b;
               b_gnt_d          = pick_b;
               mem_write_d      = pick_b ? b_we  : a_we;
               mem_read_d       = pick_b ? !b_we : !a_we;
               if (!pick_b || !b_lock) begin
                  lock_cnt_d = 4'd0;
               end else if (a_req && lock_win) begin
                  lock_cnt_d = lock_cnt_q + 4'd1;
               end
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (req_we_q) begin
               state_d = IDLE;
            end else if (READ_LATENCY == 0) begin
               rdata_d    = mem_read_data;
               a_rvalid_d = !owner_b_q;
               b_rvalid_d = owner_b_q;
               state_d    = RESP;
            end else begin
               wait_cnt_d = WAIT_INIT;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q == 2'd0) begin
               rdata_d    = mem_read_data;
               a_rvalid_d = !owner_b_q;
               b_rvalid_d = owner_b_q;
               state_d    = RESP;
            end else begin
               wait_cnt_d = wait_cnt_q - 2'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         owner_b_q        <= 1'b1;
         lock_cnt_q       <= 4'd0;
         req_we_q         <= 1'b0;
         wait_cnt_q       <= 2'd0;
         a_gnt_q          <= 1'b0;
         b_gnt_q          <= 1'b0;
         a_rvalid_q       <= 1'b0;
         b_rvalid_q       <= 1'b0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
         busy_q           <= 1'b0;
         mem_address_q    <= ZERO_ADDR;
         mem_write_data_q <= ZERO_WORD;
         rdata_q          <= ZERO_WORD;
      end else begin
         state_q          <= state_d;
         owner_b_q        <= owner_b_d;
         lock_cnt_q       <= lock_cnt_d;
         req_we_q         <= req_we_d;
         wait_cnt_q       <= wait_cnt_d;
         a_gnt_q          <= a_gnt_d;
         b_gnt_q          <= b_gnt_d;
         a_rvalid_q       <= a_rvalid_d;
         b_rvalid_q       <= b_rvalid_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
         busy_q           <= busy_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         rdata_q          <= rdata_d;
      end
   end

   assign a_gnt          = a_gnt_q;
   assign b_gnt          = b_gnt_q;
   assign a_rvalid       = a_rvalid_q;
   assign b_rvalid       = b_rvalid_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign busy           = busy_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign rdata          = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: one instance with READ_LATENCY=0, one with 3,
// directed cycle tables and sequences plus random traffic against a transaction model.
module tb_mem_arbiter;

   localparam int WS = 9;
   localparam int AS = 6;
   localparam int DW = 2 * WS;
   localparam int AW = 2 * AS;
   localparam logic [AW-1:0] A_ADDR  = 12'h5A3;
   localparam logic [AW-1:0] B_ADDR  = 12'h1C6;
   localparam logic [DW-1:0] A_WDATA = 18'h2_9A51;
   localparam logic [DW-1:0] B_WDATA = 18'h1_6C2E;

   logic clock;
   logic rst0, rst1;
   logic          a_req [2], a_we [2], b_req [2], b_we [2], b_lock [2];
   logic [AW-1:0] a_addr [2], b_addr [2];
   logic [DW-1:0] a_wdata [2], b_wdata [2];
   logic          a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2];
   logic          mem_read [2], mem_write [2], busy [2];
   logic [DW-1:0] rdata [2], mem_write_data [2];
   logic [AW-1:0] mem_address [2];
   logic [DW-1:0] mrd0, mrd1;

   int checks = 0;
   int fails  = 0;

   // Word stored at an address; the memory drives its complement when data is not yet valid
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] addr);
      return {addr[5:0], addr} ^ 18'h2_A5C3;
   endfunction

   mem_arbiter #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .READ_LATENCY(0), .MAX_LOCK(8)) u_arb0 (
      .clock(clock), .reset(rst0),
      .a_req(a_req[0]), .a_we(a_we[0]), .a_addr(a_addr[0]), .a_wdata(a_wdata[0]),
      .b_req(b_req[0]), .b_we(b_we[0]), .b_addr(b_addr[0]), .b_wdata(b_wdata[0]),
      .b_lock(b_lock[0]),
      .a_gnt(a_gnt[0]), .b_gnt(b_gnt[0]), .a_rvalid(a_rvalid[0]), .b_rvalid(b_rvalid[0]),
      .rdata(rdata[0]), .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_read_data(mrd0), .busy(busy[0])
   );

   mem_arbiter #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .READ_LATENCY(3), .MAX_LOCK(8)) u_arb1 (
      .clock(clock), .reset(rst1),
      .a_req(a_req[1]), .a_we(a_we[1]), .a_addr(a_addr[1]), .a_wdata(a_wdata[1]),
      .b_req(b_req[1]), .b_we(b_we[1]), .b_addr(b_addr[1]), .b_wdata(b_wdata[1]),
      .b_lock(b_lock[1]),
      .a_gnt(a_gnt[1]), .b_gnt(b_gnt[1]), .a_rvalid(a_rvalid[1]), .b_rvalid(b_rvalid[1]),
      .rdata(rdata[1]), .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_read_data(mrd1), .busy(busy[1])
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Zero-latency memory answers in the strobe cycle itself
   assign mrd0 = mem_read[0] ? mem_word(mem_address[0]) : ~mem_word(mem_address[0]);

   // Three-cycle memory: data valid only in the third cycle after the strobe
   int            since1;
   logic [AW-1:0] saddr1;
   always @(posedge clock or negedge rst1) begin
      if (!rst1) begin
         since1 <= 0;
         saddr1 <= '0;
      end else if (mem_read[1]) begin
         since1 <= 1;
         saddr1 <= mem_address[1];
      end else if (since1 > 0 && since1 < 10) begin
         since1 <= since1 + 1;
      end
   end
   assign mrd1 = (since1 == 3) ? mem_word(saddr1) : ~mem_word(saddr1);

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input bit ar, input bit aw, input logic [AW-1:0] aa,
                                input logic [DW-1:0] ad, input bit br, input bit bw,
                                input logic [AW-1:0] ba, input logic [DW-1:0] bd, input bit bl);
      a_req[idx] = ar; a_we[idx] = aw; a_addr[idx] = aa; a_wdata[idx] = ad;
      b_req[idx] = br; b_we[idx] = bw; b_addr[idx] = ba; b_wdata[idx] = bd;
      b_lock[idx] = bl;
   endtask

   task automatic resetDut(input int idx);
      applyStimulus(idx, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      @(negedge clock);
      if (idx == 0) rst0 = 1'b0; else rst1 = 1'b0;
      @(negedge clock);
      @(negedge clock);
      if (idx == 0) rst0 = 1'b1; else rst1 = 1'b1;
   endtask

   task automatic checkResetState(input int idx, input string tag);
      checkOutput({tag, " a_gnt"}, 32'(a_gnt[idx]), 0);
      checkOutput({tag, " b_gnt"}, 32'(b_gnt[idx]), 0);
      checkOutput({tag, " a_rvalid"}, 32'(a_rvalid[idx]), 0);
      checkOutput({tag, " b_rvalid"}, 32'(b_rvalid[idx]), 0);
      checkOutput({tag, " mem_read"}, 32'(mem_read[idx]), 0);
      checkOutput({tag, " mem_write"}, 32'(mem_write[idx]), 0);
      checkOutput({tag, " busy"}, 32'(busy[idx]), 0);
      checkOutput({tag, " mem_address"}, 32'(mem_address[idx]), 0);
      checkOutput({tag, " mem_write_data"}, 32'(mem_write_data[idx]), 0);
      checkOutput({tag, " rdata"}, 32'(rdata[idx]), 0);
   endtask

   typedef struct {
      bit ar, aw, br, bw;
      bit e_agnt, e_bgnt, e_arv, e_brv, e_rd, e_wr, e_busy;
      int e_sel;
      bit e_rdata;
   } vec_t;

   // Random traffic against a transaction-level model of the arbitration and timing rules
   task automatic runRandom(input int idx, input int rl, input int ncycles);
      bit            pend [2];
      int            pend_g [2];
      bit            pw [2];
      logic [AW-1:0] paddr [2];
      logic [DW-1:0] pdata [2];
      int cur_g = -10, cur_end = 0, cur_owner = 0;
      bit cur_we = 1;
      logic [AW-1:0] cur_addr = '0;
      logic [DW-1:0] cur_wdata = '0;
      bit last_b = 1;
      int lock = 0;
      bit lockv, pick_b, lockwin;
      bit e_gnt, e_rv;
      string tag;
      pend[0] = 0; pend[1] = 0; pend_g[0] = -1; pend_g[1] = -1;
      resetDut(idx);
      for (int t = 0; t < ncycles; t++) begin
         @(negedge clock);
         tag = $sformatf("rnd%0d t=%0d", idx, t);
         e_gnt = (t == cur_g);
         e_rv  = !cur_we && (t == cur_g + 1 + rl);
         checkOutput({tag, " a_gnt"}, 32'(a_gnt[idx]), 32'(e_gnt && cur_owner == 0));
         checkOutput({tag, " b_gnt"}, 32'(b_gnt[idx]), 32'(e_gnt && cur_owner == 1));
         checkOutput({tag, " mem_write"}, 32'(mem_write[idx]), 32'(e_gnt && cur_we));
         checkOutput({tag, " mem_read"}, 32'(mem_read[idx]), 32'(e_gnt && !cur_we));
         checkOutput({tag, " a_rvalid"}, 32'(a_rvalid[idx]), 32'(e_rv && cur_owner == 0));
         checkOutput({tag, " b_rvalid"}, 32'(b_rvalid[idx]), 32'(e_rv && cur_owner == 1));
         checkOutput({tag, " busy"}, 32'(busy[idx]), 32'(t >= cur_g && t < cur_end));
         if (e_gnt) begin
            checkOutput({tag, " mem_address"}, 32'(mem_address[idx]), 32'(cur_addr));
            if (cur_we) checkOutput({tag, " mem_write_data"}, 32'(mem_write_data[idx]), 32'(cur_wdata));
         end
         if (e_rv) checkOutput({tag, " rdata"}, 32'(rdata[idx]), 32'(mem_word(cur_addr)));

         for (int p = 0; p < 2; p++) begin
            if (pend[p] && pend_g[p] >= 0 && t > pend_g[p]) pend[p] = 0;
            if (!pend[p] && $urandom_range(0, 99) < 45) begin
               pend[p]   = 1;
               pend_g[p] = -1;
               pw[p]     = 1'($urandom_range(0, 1));
               paddr[p]  = AW'($urandom);
               pdata[p]  = DW'($urandom);
            end
         end
         lockv = ($urandom_range(0, 3) != 0);
         applyStimulus(idx, pend[0], pw[0], paddr[0], pdata[0], pend[1], pw[1], paddr[1], pdata[1], lockv);

         if (t >= cur_end && (pend[0] || pend[1])) begin
            lockwin = 0;
            if (!(pend[0] && pend[1])) pick_b = pend[1];
            else if (last_b && lockv && lock < 8) begin pick_b = 1; lockwin = 1; end
            else pick_b = !last_b;
            if (!pick_b || !lockv) lock = 0;
            else if (lockwin) lock++;
            last_b    = pick_b;
            cur_owner = pick_b ? 1 : 0;
            cur_we    = pw[cur_owner];
            cur_addr  = paddr[cur_owner];
            cur_wdata = pdata[cur_owner];
            cur_g     = t + 1;
            cur_end   = cur_we ? t + 2 : t + 3 + rl;
            pend_g[cur_owner] = t + 1;
         end
      end
      applyStimulus(idx, 0, 0, '0, '0, 0, 0, '0, '0, 0);
   endtask

   initial begin
      vec_t tbl [9];
      int   got [$];
      int   exp_lock [11];
      int   k;

      rst0 = 1'b1; rst1 = 1'b1;
      applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      #2;
      rst0 = 1'b0; rst1 = 1'b0;
      #1;
      checkResetState(0, "reset0");
      checkResetState(1, "reset1");
      @(negedge clock);
      @(negedge clock);
      rst0 = 1'b1; rst1 = 1'b1;

      // Two simultaneous writes after reset (A first), then a single zero-latency A read
      tbl[0] = '{1,1,1,1, 0,0,0,0,0,0,0, 0, 0};
      tbl[1] = '{1,1,1,1, 1,0,0,0,0,1,1, 1, 0};
      tbl[2] = '{0,1,1,1, 0,0,0,0,0,0,0, 0, 0};
      tbl[3] = '{0,1,1,1, 0,1,0,0,0,1,1, 2, 0};
      tbl[4] = '{0,0,0,0, 0,0,0,0,0,0,0, 0, 0};
      tbl[5] = '{1,0,0,0, 0,0,0,0,0,0,0, 0, 0};
      tbl[6] = '{1,0,0,0, 1,0,0,0,1,0,1, 1, 0};
      tbl[7] = '{0,0,0,0, 0,0,1,0,0,0,1, 0, 1};
      tbl[8] = '{0,0,0,0, 0,0,0,0,0,0,0, 0, 0};
      for (int i = 0; i < 9; i++) begin
         string tag;
         @(negedge clock);
         tag = $sformatf("tbl row%0d", i);
         checkOutput({tag, " a_gnt"}, 32'(a_gnt[0]), 32'(tbl[i].e_agnt));
         checkOutput({tag, " b_gnt"}, 32'(b_gnt[0]), 32'(tbl[i].e_bgnt));
         checkOutput({tag, " a_rvalid"}, 32'(a_rvalid[0]), 32'(tbl[i].e_arv));
         checkOutput({tag, " b_rvalid"}, 32'(b_rvalid[0]), 32'(tbl[i].e_brv));
         checkOutput({tag, " mem_read"}, 32'(mem_read[0]), 32'(tbl[i].e_rd));
         checkOutput({tag, " mem_write"}, 32'(mem_write[0]), 32'(tbl[i].e_wr));
         checkOutput({tag, " busy"}, 32'(busy[0]), 32'(tbl[i].e_busy));
         if (tbl[i].e_sel == 1) begin
            checkOutput({tag, " mem_address"}, 32'(mem_address[0]), 32'(A_ADDR));
            checkOutput({tag, " mem_write_data"}, 32'(mem_write_data[0]), 32'(A_WDATA));
         end else if (tbl[i].e_sel == 2) begin
            checkOutput({tag, " mem_address"}, 32'(mem_address[0]), 32'(B_ADDR));
            checkOutput({tag, " mem_write_data"}, 32'(mem_write_data[0]), 32'(B_WDATA));
         end
         if (tbl[i].e_rdata) checkOutput({tag, " rdata"}, 32'(rdata[0]), 32'(mem_word(A_ADDR)));
         applyStimulus(0, tbl[i].ar, tbl[i].aw, A_ADDR, A_WDATA, tbl[i].br, tbl[i].bw, B_ADDR, B_WDATA, 0);
      end

      // B locked burst with A waiting: 9 B grants, then A, then B again
      $display("[TB] lock burst sequence");
      resetDut(0);
      exp_lock = '{1,1,1,1,1,1,1,1,1,0,1};
      @(negedge clock);
      applyStimulus(0, 0, 1, A_ADDR, A_WDATA, 1, 1, B_ADDR, B_WDATA, 1);
      got.delete();
      for (int c = 1; c < 100 && got.size() < 11; c++) begin
         @(negedge clock);
         if (c == 1) applyStimulus(0, 1, 1, A_ADDR, A_WDATA, 1, 1, B_ADDR, B_WDATA, 1);
         if (a_gnt[0]) got.push_back(0);
         if (b_gnt[0]) got.push_back(1);
      end
      checkOutput("lock grant count", 32'(got.size()), 11);
      for (int i = 0; i < 11 && i < got.size(); i++)
         checkOutput($sformatf("lock grant%0d owner", i), 32'(got[i]), 32'(exp_lock[i]));
      applyStimulus(0, 0, 0, '0, '0, 0, 0, '0, '0, 0);

      // READ_LATENCY=3 B read timing
      $display("[TB] latency-3 B read");
      resetDut(1);
      @(negedge clock);
      applyStimulus(1, 0, 0, A_ADDR, A_WDATA, 1, 0, B_ADDR, B_WDATA, 0);
      for (int c = 1; c <= 6; c++) begin
         string tag;
         @(negedge clock);
         tag = $sformatf("rl3 cyc%0d", c);
         checkOutput({tag, " b_gnt"}, 32'(b_gnt[1]), 32'(c == 1));
         checkOutput({tag, " mem_read"}, 32'(mem_read[1]), 32'(c == 1));
         checkOutput({tag, " b_rvalid"}, 32'(b_rvalid[1]), 32'(c == 5));
         checkOutput({tag, " a_rvalid"}, 32'(a_rvalid[1]), 0);
         checkOutput({tag, " busy"}, 32'(busy[1]), 32'(c <= 5));
         if (c <= 4) checkOutput({tag, " mem_address"}, 32'(mem_address[1]), 32'(B_ADDR));
         if (c == 5) checkOutput({tag, " rdata"}, 32'(rdata[1]), 32'(mem_word(B_ADDR)));
         if (c == 2) applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      end

      // Both ports reading continuously without lock alternate A,B,A,B...
      $display("[TB] alternating reads");
      resetDut(1);
      @(negedge clock);
      applyStimulus(1, 1, 0, A_ADDR, A_WDATA, 1, 0, B_ADDR, B_WDATA, 0);
      got.delete();
      for (int c = 1; c < 200 && got.size() < 8; c++) begin
         @(negedge clock);
         if (a_gnt[1]) got.push_back(0);
         if (b_gnt[1]) got.push_back(1);
      end
      checkOutput("alt grant count", 32'(got.size()), 8);
      for (int i = 0; i < 8 && i < got.size(); i++)
         checkOutput($sformatf("alt grant%0d owner", i), 32'(got[i]), 32'(i % 2));
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);

      // Reset asserted during the WAIT of an A read aborts it cleanly
      $display("[TB] reset during wait");
      resetDut(1);
      @(negedge clock);
      applyStimulus(1, 1, 0, A_ADDR, A_WDATA, 0, 0, '0, '0, 0);
      @(negedge clock);
      checkOutput("abort a_gnt", 32'(a_gnt[1]), 1);
      @(negedge clock);
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      checkOutput("abort in wait busy", 32'(busy[1]), 1);
      rst1 = 1'b0;
      #1;
      checkResetState(1, "abort");
      @(negedge clock);
      rst1 = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clock);
         checkOutput($sformatf("abort post%0d a_rvalid", c), 32'(a_rvalid[1]), 0);
         checkOutput($sformatf("abort post%0d busy", c), 32'(busy[1]), 0);
      end
      applyStimulus(1, 1, 0, B_ADDR, A_WDATA, 0, 0, '0, '0, 0);
      @(negedge clock);
      checkOutput("after abort a_gnt", 32'(a_gnt[1]), 1);
      checkOutput("after abort mem_address", 32'(mem_address[1]), 32'(B_ADDR));
      applyStimulus(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
      k = 0;
      repeat (4) begin
         @(negedge clock);
         k++;
      end
      checkOutput("after abort a_rvalid", 32'(a_rvalid[1]), 1);
      checkOutput("after abort rdata", 32'(rdata[1]), 32'(mem_word(B_ADDR)));

      $display("[TB] random traffic");
      runRandom(0, 0, 400);
      runRandom(1, 3, 400);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
